// File: rtl/negedge_deser_pkg.sv
// negedge_deser_pkg: shared width defaults and counter sizing for the negedge deserializer
package negedge_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/negedge_deser_shift.sv
// negedge_deser_shift: LSB-first shift register and bit counter with word-completion strobe
module negedge_deser_shift
    import negedge_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;

    // word is the value sh takes on this edge; done flags it as complete
    always_comb begin
        word = {sin, sh[WIDTH-1:1]};
        done = sin_valid && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (sin_valid) begin
            sh  <= word;
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/negedge_deser.sv
// negedge_deser: falling-edge serial-to-parallel deserializer with valid/ready holding register
module negedge_deser
    import negedge_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] word;
    logic             done;
    logic             fire;
    logic             load;
    logic             drop;

    negedge_deser_shift #(.WIDTH(WIDTH)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_valid (sin_valid),
        .word      (word),
        .done      (done)
    );

    // a word completing while the held one is consumed loads back-to-back
    always_comb begin
        fire = dout_valid && out_ready;
        load = done && (!dout_valid || fire);
        drop = done && dout_valid && !out_ready;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout       <= load ? word : dout;
            dout_valid <= load ? 1'b1 : (fire ? 1'b0 : dout_valid);
            overrun    <= overrun || drop;
        end
    end

endmodule

// File: tb/tb_negedge_deser.sv
// tb_negedge_deser: directed checks of the negedge deserializer at WIDTH=8 and WIDTH=2
module tb_negedge_deser;

    logic       clk;
    logic       reset;
    logic       sin, sin_valid, out_ready;
    logic [7:0] dout;
    logic       dout_valid, overrun;
    logic       sin2, sin_valid2, out_ready2;
    logic [1:0] dout2;
    logic       dout_valid2, overrun2;
    int         checks = 0;
    int         errors = 0;

    negedge_deser #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

    negedge_deser #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin2),
        .sin_valid  (sin_valid2),
        .out_ready  (out_ready2),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .overrun    (overrun2)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic r);
        sin       = s;
        sin_valid = v;
        out_ready = r;
    endtask

    task automatic feed(input logic [7:0] w, input int lo, input int hi, input logic r);
        for (int i = lo; i <= hi; i++) begin
            drive(w[i], 1'b1, r);
            edge_step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        edge_step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        sin2 = 1'b0; sin_valid2 = 1'b0; out_ready2 = 1'b0;
        #2;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        edge_step();
        reset = 1'b1;

        // basic word 0x4D, ready low
        feed(8'h4D, 0, 6, 1'b0);
        chk("w1_valid_early", 32'(dout_valid), 32'h0);
        feed(8'h4D, 7, 7, 1'b0);
        chk("w1_dout", 32'(dout), 32'h4D);
        chk("w1_valid", 32'(dout_valid), 32'h1);
        chk("w1_overrun", 32'(overrun), 32'h0);

        // gapped stream: invalid edges carry inverted garbage bits
        do_reset();
        for (int e = 0; e < 15; e++) begin
            logic [7:0] w;
            w = 8'h4D;
            if (e % 2 == 0) drive(w[e/2], 1'b1, 1'b0);
            else            drive(~w[e/2], 1'b0, 1'b0);
            edge_step();
            if (e == 13) chk("gap_valid_early", 32'(dout_valid), 32'h0);
        end
        chk("gap_dout", 32'(dout), 32'h4D);
        chk("gap_valid", 32'(dout_valid), 32'h1);

        // A5 then 3C; consume coincides with second completion
        do_reset();
        feed(8'hA5, 0, 7, 1'b1);
        chk("b2b_first", 32'(dout), 32'hA5);
        chk("b2b_first_valid", 32'(dout_valid), 32'h1);
        feed(8'h3C, 0, 6, 1'b0);
        chk("b2b_hold_valid", 32'(dout_valid), 32'h1);
        chk("b2b_hold_dout", 32'(dout), 32'hA5);
        feed(8'h3C, 7, 7, 1'b1);
        chk("b2b_second", 32'(dout), 32'h3C);
        chk("b2b_second_valid", 32'(dout_valid), 32'h1);
        chk("b2b_overrun", 32'(overrun), 32'h0);
        drive(1'b0, 1'b0, 1'b1);
        edge_step();
        chk("b2b_consumed", 32'(dout_valid), 32'h0);

        // overrun: FF completes while A5 is held
        do_reset();
        feed(8'hA5, 0, 7, 1'b0);
        feed(8'hFF, 0, 6, 1'b0);
        chk("ovr_early", 32'(overrun), 32'h0);
        feed(8'hFF, 7, 7, 1'b0);
        chk("ovr_dout", 32'(dout), 32'hA5);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_valid", 32'(dout_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b1);
        edge_step();
        chk("ovr_consumed", 32'(dout_valid), 32'h0);
        chk("ovr_sticky", 32'(overrun), 32'h1);

        // async reset mid-word, checked before any falling edge
        feed(8'hFF, 0, 4, 1'b0);
        reset = 1'b0;
        #2;
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_valid", 32'(dout_valid), 32'h0);
        chk("arst_overrun", 32'(overrun), 32'h0);
        #2;
        reset = 1'b1;
        feed(8'h01, 0, 6, 1'b0);
        chk("arst_partial_gone", 32'(dout_valid), 32'h0);
        feed(8'h01, 7, 7, 1'b0);
        chk("arst_word", 32'(dout), 32'h01);
        chk("arst_word_valid", 32'(dout_valid), 32'h1);

        // WIDTH=2: 1,1 then 0,1 with ready high
        do_reset();
        out_ready2 = 1'b1;
        sin_valid2 = 1'b1;
        sin2 = 1'b1; edge_step();
        chk("w2_half", 32'(dout_valid2), 32'h0);
        sin2 = 1'b1; edge_step();
        chk("w2_first", 32'(dout2), 32'h3);
        chk("w2_first_valid", 32'(dout_valid2), 32'h1);
        sin2 = 1'b0; edge_step();
        chk("w2_consumed", 32'(dout_valid2), 32'h0);
        sin2 = 1'b1; edge_step();
        chk("w2_second", 32'(dout2), 32'h2);
        chk("w2_second_valid", 32'(dout_valid2), 32'h1);
        chk("w2_overrun", 32'(overrun2), 32'h0);
        sin_valid2 = 1'b0;
        edge_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
